// File: rtl/key_expansion_seq.sv
// Sequential AES key schedule (AES-128/192/256): one expanded word per clock,
// full schedule held in a register file, 128-bit round-key read port.

// AES forward S-box, one byte lookup.
module key_expansion_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);

  // Byte 0x00 sits in the MSBs, so entry x lives at packed index 255-x (= ~x).
  localparam logic [255:0][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign y = SBOX[~a];

endmodule

module key_expansion_seq #(
  parameter int unsigned NK = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [32*NK-1:0]  key_in,
  output logic              busy,
  output logic              done,
  output logic              valid,
  input  logic [3:0]        rk_idx,
  input  logic              rk_rev,
  output logic [127:0]      rk_out
);

  localparam int unsigned NR = NK + 6;
  localparam int unsigned NW = 4 * (NR + 1);
  localparam int unsigned IW = 6;
  localparam int unsigned MW = 3;

  // Reject unsupported key lengths at elaboration.
  if (!(NK == 4 || NK == 6 || NK == 8)) begin : g_bad_nk
    $error("key_expansion_seq: NK must be 4, 6 or 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   i_q, i_d;
  logic [MW-1:0]   m_q, m_d;
  logic [7:0]      rcon_q, rcon_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            valid_q, valid_d;
  logic [127:0]    rk_out_q, rk_out_d;

  logic            load_c, we_c;
  logic [31:0]     prev_c, back_c, sub_in_c, sub_out_c, temp_c, wdata_c;
  logic [3:0]      k_c;
  logic [IW-1:0]   base_c;

  logic [31:0]     w_q [NW];

  // Shared SubWord: four S-box lookups.
  for (genvar b = 0; b < 4; b++) begin : g_sbox
    key_expansion_sbox u_sbox (
      .a (sub_in_c[8*b +: 8]),
      .y (sub_out_c[8*b +: 8])
    );
  end

  // Next schedule word from w[i-1] and w[i-NK]; m_q tracks i mod NK.
  always_comb begin
    prev_c   = w_q[i_q - IW'(1)];
    back_c   = w_q[i_q - IW'(NK)];
    sub_in_c = (m_q == '0) ? {prev_c[23:0], prev_c[31:24]} : prev_c;
    temp_c   = prev_c;
    if (m_q == '0) begin
      temp_c = sub_out_c ^ {rcon_q, 24'h0};
    end else if (NK == 8 && m_q == MW'(4)) begin
      temp_c = sub_out_c;
    end
    wdata_c = back_c ^ temp_c;
  end

  // Control FSM next state and registered status outputs.
  always_comb begin
    state_d = state_q;
    i_d     = i_q;
    m_d     = m_q;
    rcon_d  = rcon_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    valid_d = valid_q;
    load_c  = 1'b0;
    we_c    = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          load_c  = 1'b1;
          i_d     = IW'(NK);
          m_d     = '0;
          rcon_d  = 8'h01;
          busy_d  = 1'b1;
          valid_d = 1'b0;
          state_d = S_EXPAND;
        end
      end
      S_EXPAND: begin
        we_c = 1'b1;
        i_d  = i_q + IW'(1);
        m_d  = (m_q == MW'(NK - 1)) ? '0 : m_q + MW'(1);
        if (m_q == '0) begin
          rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        end
        if (i_q == IW'(NW - 1)) begin
          busy_d  = 1'b0;
          done_d  = 1'b1;
          valid_d = 1'b1;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Round-key read: range check on the raw index, then optional mirror.
  always_comb begin
    k_c    = rk_rev ? (4'(NR) - rk_idx) : rk_idx;
    base_c = {k_c, 2'b00};
    if (rk_idx > 4'(NR)) begin
      rk_out_d = '0;
    end else begin
      rk_out_d = {w_q[base_c], w_q[base_c + IW'(1)],
                  w_q[base_c + IW'(2)], w_q[base_c + IW'(3)]};
    end
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      m_q      <= '0;
      rcon_q   <= 8'h01;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      valid_q  <= 1'b0;
      rk_out_q <= '0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      m_q      <= m_d;
      rcon_q   <= rcon_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      valid_q  <= valid_d;
      rk_out_q <= rk_out_d;
    end
  end

  // Schedule storage: bulk key load on start, one word per expansion cycle.
  always_ff @(posedge clk) begin
    if (load_c) begin
      for (int j = 0; j < int'(NK); j++) begin
        w_q[j] <= key_in[32*(int'(NK)-1-j) +: 32];
      end
    end else if (we_c) begin
      w_q[i_q] <= wdata_c;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign valid  = valid_q;
  assign rk_out = rk_out_q;

endmodule

// File: doc/key_expansion_seq.md
# key_expansion_seq

Sequential, parametrised AES key-schedule generator for AES-128/192/256. It captures a cipher key on a start pulse, produces one expanded word per clock using four shared S-box lookups, and holds the complete schedule in a register file. The round datapath reads 128-bit round keys from that register file, in forward order for encryption or reverse order for decryption. It sits between the SPI key-load logic and the encrypt/decrypt round cores.

## Interface
Parameters:
- `NK`, default 4: key length in 32-bit words; legal values 4, 6, 8. Any other value is a compile-time error.
- `NR`, derived `NK+6`: number of rounds.
- `NW`, derived `4*(NR+1)`: total schedule words (44/52/60).

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request to expand `key_in`.
- `key_in`  in  32*NK  cipher key, word 0 in the MSBs (FIPS-197 byte order).
- `busy`  out  1  expansion in progress.
- `done`  out  1  one-cycle pulse when the schedule is complete.
- `valid`  out  1  schedule complete and readable; level signal.
- `rk_idx`  in  4  round-key index, 0..NR.
- `rk_rev`  in  1  1 = read round key `NR-rk_idx` (decrypt order).
- `rk_out`  out  128  registered round key: words 4k..4k+3, with word 4k in the MSBs.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- **IDLE:**
  - `start` captures `key_in` into w[0..NK-1].
  - Sets word counter i=NK and rcon=0x01.
  - Next state EXPAND.
- **EXPAND:** each cycle writes w[i] and increments i.
  - temp = w[i-1].
  - If i%NK==0: temp = SubWord(RotWord(temp)) ^ {rcon,24'h0}, then rcon <= xtime(rcon) (multiply by 2 modulo 0x11B; 0x80 becomes 0x1B).
  - Else if NK==8 and i%NK==4: temp = SubWord(temp).
  - w[i] = w[i-NK] ^ temp.
  - After writing w[NW-1], next state DONE.
  - Use exactly 4 S-box instances (one SubWord). Track i%NK with a modulo counter, not a divider.
- **DONE:**
  - `valid`=1 and holds until the next accepted `start` or reset.
  - `start` in DONE restarts exactly as from IDLE: `valid` clears on the accepting edge.
- `start` while `busy` is ignored; the expansion in progress is unaffected.
- `key_in` is sampled only on the accepting edge; later changes have no effect.
- **Read port:**
  - Effective index k = `rk_rev` ? NR-`rk_idx` : `rk_idx`.
  - `rk_out` <= {w[4k],w[4k+1],w[4k+2],w[4k+3]}.
  - `rk_idx` > NR yields `rk_out`=0. With `rk_rev`=1, the index is range-checked before mirroring.
  - Reads are permitted in any state. Contents are only meaningful when `valid`=1; consumers gate on `valid`.

## Timing
- Reset (async assert, sync-safe deassert): state IDLE, `busy`=0, `done`=0, `valid`=0, `rk_out`=0, i=0, rcon=0x01. Word storage need not be cleared.
- Reset mid-expansion aborts immediately; `valid` stays 0 until a new full expansion completes.
- Edge E0 (`start` sampled in IDLE/DONE): key loaded, `busy`=1 from E0.
- Edges E1..E(NW-NK) write w[NK]..w[NW-1]. This is 40/46/52 cycles for NK=4/6/8.
- At edge E(NW-NK): `busy`=0, `done`=1 for exactly one cycle, `valid`=1.
- Start-to-done latency is NW-NK clock cycles.
- `rk_out` read latency is 1 cycle: index presented at edge n appears after edge n.
- Back-to-back: `start` in the same cycle `done` is high is accepted (state is DONE).

## Test plan
- **AES-128:** NK=4, key 2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - `done` exactly 40 cycles after `start`.
  - rk_idx=1 -> a0fafe17_88542cb1_23a33939_2a6c7605.
  - rk_idx=10 -> d014f9a8_c9ee2589_e13f0cc8_b6630ca6.
- **AES-192:** NK=6, key 8e73b0f7_da0e6452_c810f32b_809079e5_62f8ead2_522c6b7b.
  - `done` after 46 cycles.
  - rk_idx=12 -> e98ba06f_448c773c_8ecc7204_01002202.
- **AES-256:** NK=8, key 603deb10_15ca71be_2b73aef0_857d7781_1f352c07_3b6108d7_2d9810a3_0914dff4.
  - `done` after 52 cycles.
  - rk_idx=14 -> fe4890d1_e6188d0b_046df344_706c631e (exercises the i%8==4 SubWord path).
- **Reverse read and out-of-range:** NK=4 with the AES-128 key.
  - rk_rev=1, rk_idx=0 -> round-10 key.
  - rk_rev=1, rk_idx=10 -> 2b7e1516_28aed2a6_abf71588_09cf4f3c.
  - rk_idx=11 -> 0.
- **Start while busy:** second `start` with a different key at cycle 10 is ignored; `done` still at cycle 40 and results match the first key.
- **Reset mid-operation:** `rst_n` low at cycle 20.
  - Outputs 0 immediately.
  - A new `start` after release gives a full 40-cycle expansion with correct keys.
  - A restart from DONE drops `valid` on the accepting edge.
